// File: rtl/pwm_deserializer.sv
// pwm_deserializer: recovers the duty cycle (0..99, 100 = stuck high) from an
// incoming PWM line sampled on clk. Measures high time and period between
// consecutive rising edges, flags out-of-tolerance periods and dead lines.
// Optional glitch filter enabled by defining PWM_DESER_GLITCH_EN.
module pwm_deserializer #(
  parameter int unsigned PULSE_FREQ = 1,
  parameter int unsigned SYS_FREQ   = 100,
  parameter int unsigned PERIOD_TOL = 2,
  parameter int unsigned GLITCH_CYC = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pwm_in,
  output logic [6:0] duty_out,
  output logic       duty_valid,
  output logic       period_err,
  output logic       signal_lost
);

  localparam int unsigned WINDOW   = SYS_FREQ / PULSE_FREQ;
  localparam int unsigned CNT_MAX  = 2 * WINDOW;
  localparam int unsigned CNT_BITS = $clog2(CNT_MAX) + 1;
  localparam logic [CNT_BITS-1:0] CNT_SAT = CNT_BITS'(CNT_MAX);
  localparam logic [CNT_BITS-1:0] WIN_LO  = CNT_BITS'(WINDOW - PERIOD_TOL);
  localparam logic [CNT_BITS-1:0] WIN_HI  = CNT_BITS'(WINDOW + PERIOD_TOL);
  localparam logic [CNT_BITS-1:0] DUTY_CAP = CNT_BITS'(99);

  if (GLITCH_CYC < 1) begin : g_bad_glitch
    $error("GLITCH_CYC must be at least 1");
  end
  if (PERIOD_TOL >= WINDOW) begin : g_bad_tol
    $error("PERIOD_TOL must be smaller than the PWM window");
  end

  typedef enum logic [2:0] {
    IDLE,
    HIGH,
    LOW,
    STUCK_HI,
    STUCK_LO
  } state_t;

  logic sync1_q, sync1_d, sync2_q, sync2_d;
  logic s, s_d_q, s_d_d;
  logic rise_q, rise_d, fall_q, fall_d, lvl_q, lvl_d;

`ifdef PWM_DESER_GLITCH_EN
  localparam int unsigned GLT_BITS = $clog2(GLITCH_CYC + 1);
  logic                filt_q, filt_d;
  logic [GLT_BITS-1:0] glt_cnt_q, glt_cnt_d;

  // Glitch filter: follow the synchronized level only after GLITCH_CYC
  // consecutive differing samples, so both edges shift by the same amount.
  always_comb begin
    filt_d    = filt_q;
    glt_cnt_d = glt_cnt_q;
    if (sync2_q == filt_q) begin
      glt_cnt_d = '0;
    end else if (glt_cnt_q == GLT_BITS'(GLITCH_CYC - 1)) begin
      filt_d    = sync2_q;
      glt_cnt_d = '0;
    end else begin
      glt_cnt_d = glt_cnt_q + 1'b1;
    end
  end

  // Glitch filter state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q    <= 1'b0;
      glt_cnt_q <= '0;
    end else begin
      filt_q    <= filt_d;
      glt_cnt_q <= glt_cnt_d;
    end
  end

  assign s = filt_q;
`else
  assign s = sync2_q;
`endif

  // Synchronizer next values and registered edge detection.
  always_comb begin
    sync1_d = pwm_in;
    sync2_d = sync1_q;
    s_d_d   = s;
    rise_d  = s & ~s_d_q;
    fall_d  = ~s & s_d_q;
    lvl_d   = s;
  end

  // Input path registers: 2-flop synchronizer, delayed copy, edge flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      s_d_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      lvl_q   <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      s_d_q   <= s_d_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      lvl_q   <= lvl_d;
    end
  end

  state_t              state_q, state_d;
  logic [CNT_BITS-1:0] high_q, high_d, per_q, per_d, high_inc, per_inc;
  logic [6:0]          duty_q, duty_d;
  logic                valid_q, valid_d, err_q, err_d, lost_q, lost_d;
  logic                timeout;

  // Measurement FSM next-state logic; edges take priority over the timeout.
  always_comb begin
    state_d  = state_q;
    high_d   = high_q;
    per_d    = per_q;
    duty_d   = duty_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    lost_d   = lost_q;
    high_inc = (high_q == CNT_SAT) ? high_q : high_q + 1'b1;
    per_inc  = (per_q == CNT_SAT) ? per_q : per_q + 1'b1;
    timeout  = (per_q >= CNT_SAT);

    if ((state_q == IDLE || state_q == HIGH || state_q == LOW) &&
        !rise_q && !(state_q == HIGH && fall_q) && timeout) begin
      state_d = lvl_q ? STUCK_HI : STUCK_LO;
      duty_d  = lvl_q ? 7'd100 : 7'd0;
      lost_d  = 1'b1;
      err_d   = 1'b0;
      valid_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE, STUCK_LO: begin
          if (state_q == IDLE) per_d = per_inc;
          if (rise_q) begin
            high_d  = CNT_BITS'(1);
            per_d   = CNT_BITS'(1);
            state_d = HIGH;
          end
        end
        HIGH: begin
          per_d = per_inc;
          if (fall_q) state_d = LOW;
          else        high_d  = high_inc;
        end
        LOW: begin
          if (rise_q) begin
            if (per_q >= WIN_LO && per_q <= WIN_HI) begin
              duty_d = (high_q >= DUTY_CAP) ? 7'd99 : 7'(high_q);
              err_d  = 1'b0;
            end else begin
              err_d  = 1'b1;
            end
            valid_d = 1'b1;
            lost_d  = 1'b0;
            high_d  = CNT_BITS'(1);
            per_d   = CNT_BITS'(1);
            state_d = HIGH;
          end else begin
            per_d = per_inc;
          end
        end
        STUCK_HI: begin
          if (fall_q) begin
            per_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Measurement FSM state, counters and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      high_q  <= '0;
      per_q   <= '0;
      duty_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      high_q  <= high_d;
      per_q   <= per_d;
      duty_q  <= duty_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      lost_q  <= lost_d;
    end
  end

  assign duty_out    = duty_q;
  assign duty_valid  = valid_q;
  assign period_err  = err_q;
  assign signal_lost = lost_q;

endmodule
